i2c_target: RTL and testbench

I2C target (slave) byte engine: the responder end of the I2C bus, the counterpart to the team's `i2c_core` controller. Samples the open-drain SCL/SDA lines on the system clock, detects START/STOP, matches a fixed 7-bit address, ACKs, and moves bytes between the bus and a simple local byte handshake. Sits between the pad-level open-drain buffers and a register file or FIFO. Supports only 100/400 kHz bus speeds, with `clk` at least 16x SCL.

---
 rtl/i2c_target.sv | 156 +++++++++++++++
 tb/tb_i2c_target.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// i2c_target: I2C target byte engine (fixed address, ACK generation, local byte handshake).
// Optional SCL clock stretching when I2C_TARGET_CLK_STRETCH_EN is defined.
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_o,
    output logic [7:0] rxdata,
    output logic       rx_valid,
    input  logic [7:0] txdata,
    input  logic       tx_load,
    output logic       tx_req,
    output logic       addressed,
    output logic       rw,
    output logic       stop_det
);
`ifdef I2C_TARGET_CLK_STRETCH_EN
    localparam logic STRETCH = 1'b1;
`else
    localparam logic STRETCH = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT} state_t;

    state_t state, nxt;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_d, sda_d, scl, sda;
    logic scl_rise, scl_fall, start, stop, match, load_pt, do_load;
    logic [3:0] cnt;
    logic [7:0] sh, tx_buf, next_byte;
    logic loaded, hold;

    assign scl       = scl_sync[SYNC_STAGES-1];
    assign sda       = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl & ~scl_d;
    assign scl_fall  = ~scl & scl_d;
    assign start     = scl & scl_d & sda_d & ~sda;
    assign stop      = scl & scl_d & ~sda_d & sda;
    assign match     = sh[7:1] == ADDR;
    assign next_byte = loaded ? tx_buf : txdata;
    // load point: the SCL fall that ends the address ACK (read) or an ACKed read byte
    assign load_pt   = scl_fall & ((state == S_ADDR_ACK & rw) | state == S_TX_ACK);
    assign do_load   = (load_pt & (loaded | ~STRETCH)) | (hold & loaded);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl;
            sda_d    <= sda;
        end

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= S_IDLE;
        else       state <= nxt;

    always_comb begin
        nxt = state;
        if (start) nxt = S_ADDR;
        else if (stop) nxt = S_IDLE;
        else if (do_load) nxt = S_TX;
        else if (scl_rise && state == S_TX_ACK && sda) nxt = S_WAIT;
        else if (scl_fall)
            case (state)
                S_ADDR:     if (cnt == 4'd8) nxt = match ? S_ADDR_ACK : S_WAIT;
                S_ADDR_ACK: if (!rw) nxt = S_RX;
                S_RX:       if (cnt == 4'd8) nxt = S_RX_ACK;
                S_RX_ACK:   nxt = S_RX;
                S_TX:       if (cnt == 4'd8) nxt = S_TX_ACK;
                default:    ;
            endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt       <= '0;
            sh        <= '0;
            tx_buf    <= '0;
            loaded    <= 1'b0;
            hold      <= 1'b0;
            sda_o     <= 1'b1;
            scl_o     <= 1'b1;
            rxdata    <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            addressed <= 1'b0;
            rw        <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            stop_det <= 1'b0;
            // write-side stretch lasts until rx_valid has been visible for a cycle
            if (rx_valid) scl_o <= 1'b1;
            if (start || stop) begin
                cnt       <= '0;
                addressed <= 1'b0;
                sda_o     <= 1'b1;
                scl_o     <= 1'b1;
                hold      <= 1'b0;
                stop_det  <= stop;
            end else if (do_load) begin
                sda_o  <= next_byte[7];
                sh     <= {next_byte[6:0], 1'b1};
                loaded <= 1'b0;
                hold   <= 1'b0;
                scl_o  <= 1'b1;
            end else if (load_pt) begin
                hold  <= 1'b1;
                scl_o <= 1'b0;
            end else if (scl_rise) begin
                if (state == S_ADDR || state == S_RX) sh <= {sh[6:0], sda};
                if (state == S_ADDR || state == S_RX || state == S_TX) cnt <= cnt + 4'd1;
                if (state == S_ADDR_ACK || state == S_RX_ACK || state == S_TX_ACK) cnt <= '0;
                if ((state == S_ADDR_ACK && rw) || (state == S_TX_ACK && !sda)) begin
                    tx_req <= 1'b1;
                    loaded <= 1'b0;
                end
                if (state == S_TX_ACK && sda) addressed <= 1'b0;
            end else if (scl_fall)
                case (state)
                    S_ADDR: if (cnt == 4'd8 && match) begin
                        sda_o     <= 1'b0;
                        rw        <= sh[0];
                        addressed <= 1'b1;
                    end
                    S_ADDR_ACK, S_RX_ACK: sda_o <= 1'b1;
                    S_RX: if (cnt == 4'd8) begin
                        rxdata   <= sh;
                        rx_valid <= 1'b1;
                        sda_o    <= 1'b0;
                        scl_o    <= ~STRETCH;
                    end
                    S_TX: if (cnt == 4'd8) sda_o <= 1'b1;
                          else begin
                              sda_o <= sh[7];
                              sh    <= {sh[6:0], 1'b1};
                          end
                    default: ;
                endcase
            if (tx_load) begin
                tx_buf <= txdata;
                loaded <= 1'b1;
            end
        end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bus-controller model driving i2c_target through open-drain wiring.
module tb_i2c_target;
    localparam int Q = 5, H = 10;

    logic clk = 1'b0, reset = 1'b1, scl_m = 1'b1, sda_m = 1'b1;
    logic scl_o, sda_o, rx_valid, tx_req, addressed, rw, stop_det;
    logic tx_load = 1'b0;
    logic [7:0] rxdata;
    logic [7:0] txdata = 8'hFF;
    logic scl_i, sda_i;

    assign scl_i = scl_m & scl_o;
    assign sda_i = sda_m & sda_o;

    i2c_target dut (
        .clk(clk), .reset(reset), .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o),
        .rxdata(rxdata), .rx_valid(rx_valid), .txdata(txdata), .tx_load(tx_load), .tx_req(tx_req),
        .addressed(addressed), .rw(rw), .stop_det(stop_det)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0;
    int rxv_n = 0, txr_n = 0, stop_n = 0, sda_low_n = 0, scl_run = 0, scl_run_max = 0;
    logic [7:0] rx_last = 8'h00;

    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_n++;
            rx_last = rxdata;
        end
        if (tx_req) txr_n++;
        if (stop_det) stop_n++;
        if (!sda_o) sda_low_n++;
        scl_run = scl_o ? 0 : scl_run + 1;
        if (scl_run > scl_run_max) scl_run_max = scl_run;
    end

    // local host: answers each tx_req with the next queued byte, then scrambles txdata
    logic [7:0] tx_q [5] = '{8'h96, 8'h5A, 8'hC3, 8'h00, 8'hA5};
    int tx_idx = 0, resp_dly = 3;
    bit resp_stretch = 1'b0;
    initial forever begin
        @(negedge clk);
        if (tx_req) begin
            if (resp_stretch) for (int i = 0; i < 200 && scl_o; i++) @(negedge clk);
            repeat (resp_dly) @(negedge clk);
            txdata  = tx_q[tx_idx];
            tx_load = 1'b1;
            @(negedge clk);
            tx_load = 1'b0;
            txdata  = 8'hFF;
            tx_idx++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scl_up;
        scl_m = 1'b1;
        for (int i = 0; i < 300 && !scl_i; i++) @(negedge clk);
        if (!scl_i) check("scl_release", {31'd0, scl_i}, 1);
    endtask

    task automatic bus_start;
        sda_m = 1'b1; cyc(Q); scl_up; cyc(H); sda_m = 1'b0; cyc(H); scl_m = 1'b0; cyc(Q);
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; cyc(Q); scl_up; cyc(H); sda_m = 1'b1; cyc(H);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; cyc(Q); scl_up; cyc(H); scl_m = 1'b0; cyc(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; cyc(Q); scl_up; cyc(H/2); b = sda_i; cyc(H/2); scl_m = 1'b0; cyc(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(nack);
    endtask

    initial begin
        logic ack, bt;
        logic [7:0] b;
        int s_rx, s_tx, s_st, s_sda;
        cyc(3);
        check("rst_sda_o", sda_o, 1);
        check("rst_scl_o", scl_o, 1);
        check("rst_rxdata", rxdata, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_addressed", addressed, 0);
        check("rst_rw", rw, 0);
        check("rst_stop_det", stop_det, 0);
        reset = 1'b0;
        cyc(5);

        s_rx = rxv_n; s_st = stop_n;
        bus_start;
        send_byte(8'hA0, ack);
        check("wr_addr_ack", ack, 0);
        check("wr_addressed", addressed, 1);
        check("wr_rw", rw, 0);
        send_byte(8'h3C, ack);
        check("wr_data_ack", ack, 0);
        bus_stop; cyc(5);
        check("wr_rx_cnt", rxv_n - s_rx, 1);
        check("wr_rx_last", rx_last, 8'h3C);
        check("wr_rxdata", rxdata, 8'h3C);
        check("wr_stop_cnt", stop_n - s_st, 1);
        check("wr_addressed_end", addressed, 0);

        s_rx = rxv_n; s_st = stop_n; s_sda = sda_low_n;
        bus_start;
        send_byte(8'hA2, ack);
        check("mm_addr_nack", ack, 1);
        send_byte(8'h55, ack);
        check("mm_data_nack", ack, 1);
        check("mm_sda_low", sda_low_n - s_sda, 0);
        check("mm_rx_cnt", rxv_n - s_rx, 0);
        check("mm_addressed", addressed, 0);
        bus_stop; cyc(5);
        check("mm_stop_cnt", stop_n - s_st, 1);

        s_tx = txr_n;
        bus_start;
        send_byte(8'hA1, ack);
        check("rd_addr_ack", ack, 0);
        check("rd_rw", rw, 1);
        check("rd_addressed", addressed, 1);
        recv_byte(b, 1'b0);
        check("rd_byte1", b, 8'h96);
        recv_byte(b, 1'b1);
        check("rd_byte2", b, 8'h5A);
        check("rd_addressed_nack", addressed, 0);
        check("rd_tx_req_cnt", txr_n - s_tx, 2);
        bus_stop; cyc(5);

        s_rx = rxv_n; s_tx = txr_n;
        bus_start;
        send_byte(8'hA0, ack);
        check("sr_wr_ack", ack, 0);
        send_byte(8'h01, ack);
        check("sr_data_ack", ack, 0);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
        bus_start;
        send_byte(8'hA1, ack);
        check("sr_addr_ack", ack, 0);
        check("sr_rw", rw, 1);
        check("sr_addressed", addressed, 1);
        check("sr_tx_req_cnt", txr_n - s_tx, 1);
        check("sr_rx_cnt", rxv_n - s_rx, 1);
        check("sr_rxdata", rxdata, 8'h01);
        recv_byte(b, 1'b1);
        check("sr_byte", b, 8'hC3);
        bus_stop; cyc(5);

        bus_start;
        send_byte(8'hA1, ack);
        check("rs_addr_ack", ack, 0);
        for (int i = 0; i < 4; i++) get_bit(bt);
        check("rs_bit3_driven", sda_o, 0);
        #3 reset = 1'b1;
        #1;
        check("rs_sda_o", sda_o, 1);
        check("rs_scl_o", scl_o, 1);
        check("rs_addressed", addressed, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(5);
        bus_start;
        send_byte(8'hA0, ack);
        check("rs_after_ack", ack, 0);
        check("rs_after_addressed", addressed, 1);
        send_byte(8'h7E, ack);
        check("rs_after_data_ack", ack, 0);
        bus_stop; cyc(5);
        check("rs_after_rxdata", rxdata, 8'h7E);

`ifdef I2C_TARGET_CLK_STRETCH_EN
        resp_stretch = 1'b1;
        resp_dly = 50;
        bus_start;
        send_byte(8'hA1, ack);
        check("st_addr_ack", ack, 0);
        recv_byte(b, 1'b1);
        check("st_byte", b, 8'hA5);
        check("st_scl_hold", {31'd0, scl_run_max >= 49}, 1);
        bus_stop; cyc(5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
